// File: rtl/iir_coeff_ctrl.sv
// Coefficient shadow/active bank controller for iir_filter: drains in-flight samples,
// swaps banks while pulsing the filter reset, then resumes sample issue.
module iir_coeff_ctrl #(
  parameter int NB = 12,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [NB-1:0]   cfg_data,
  output logic [NB-1:0]   cfg_rdata,
  input  logic            cfg_commit,
  output logic            cfg_busy,
  output logic            swap_done,
  input  logic            vIn,
  input  logic [NB-1:0]   dIn,
  output logic            rdy,
  output logic            drop,
  output logic            f_vIn,
  output logic [NB-1:0]   f_dIn,
  output logic            f_rst_n,
  output logic [3*NB-1:0] b,
  output logic [2*NB-1:0] a,
  input  logic            f_vOut,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP, REARM} state_t;

  state_t        state, state_next;
  logic [CW-1:0] inflight;
  logic [NB-1:0] shadow [5];
  logic [NB-1:0] active [5];

  // Handshake: a sample transfers on any cycle where vIn and rdy are both high;
  // vIn while rdy is low is not taken and marks drop. The filter side has no ready.
  assign f_vIn     = vIn & rdy;
  assign f_dIn     = dIn;
  assign fsm_state = state;

  // State register; f_rst_n is registered so the filter is reset alongside us.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      f_rst_n <= 1'b0;
    end else begin
      state   <= state_next;
      f_rst_n <= (state_next != SWAP);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (cfg_commit) state_next = DRAIN;
      DRAIN:   if ((inflight == '0) && !f_vOut) state_next = SWAP;
      SWAP:    state_next = REARM;
      REARM:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    rdy       = (state == RUN);
    cfg_busy  = (state != RUN);
    swap_done = (state == REARM);
  end

  // Saturating occupancy count of samples inside the filter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (f_vIn && !f_vOut && (inflight != '1)) begin
      inflight <= inflight + 1'b1;
    end else if (!f_vIn && f_vOut && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (vIn && !rdy) begin
      drop <= 1'b1;
    end
  end

  // The copy in SWAP reads the pre-edge shadow, so a same-cycle write stays pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (cfg_we && (cfg_addr < 3'd5)) shadow[cfg_addr] <= cfg_data;
      if (state == SWAP) begin
        for (int i = 0; i < 5; i++) active[i] <= shadow[i];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0:    cfg_rdata = shadow[0];
      3'd1:    cfg_rdata = shadow[1];
      3'd2:    cfg_rdata = shadow[2];
      3'd3:    cfg_rdata = shadow[3];
      3'd4:    cfg_rdata = shadow[4];
      default: cfg_rdata = '0;
    endcase
  end

  assign b = {active[2], active[1], active[0]};
  assign a = {active[4], active[3]};

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Bench for iir_coeff_ctrl: acts as a fixed-latency filter and checks every
// cycle against a transaction-level model of the bank/drain behaviour.
module tb_iir_coeff_ctrl;
  localparam int NB  = 12;
  localparam int CW  = 4;
  localparam int LAT = 3;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_COPY = 2;
  localparam int PH_ACK  = 3;

  logic            clk = 1'b0;
  logic            rst_n, cfg_we, cfg_commit, v_in, f_vout;
  logic [2:0]      cfg_addr;
  logic [NB-1:0]   cfg_data, d_in;
  logic [NB-1:0]   cfg_rdata, f_din;
  logic            cfg_busy, swap_done, rdy, drop, f_vin, f_rst_n;
  logic [3*NB-1:0] b;
  logic [2*NB-1:0] a;
  logic [1:0]      fsm_state;

  iir_coeff_ctrl #(.NB(NB), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_rdata(cfg_rdata), .cfg_commit(cfg_commit),
    .cfg_busy(cfg_busy), .swap_done(swap_done), .vIn(v_in), .dIn(d_in),
    .rdy(rdy), .drop(drop), .f_vIn(f_vin), .f_dIn(f_din), .f_rst_n(f_rst_n),
    .b(b), .a(a), .f_vOut(f_vout), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            m_phase = PH_IDLE;
  logic [NB-1:0] m_sh [5];
  logic [NB-1:0] m_act [5];
  bit            m_drop, m_frst, m_ok;
  int            pipe_q[$];
  int            n_vec, n_err;
  int            n_swaps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] old_sh [5];
    bit acc, empty;
    if (!rst_n) begin
      m_phase = PH_IDLE;
      for (int i = 0; i < 5; i++) begin
        m_sh[i] = '0;
        m_act[i] = '0;
      end
      m_drop = 0;
      m_frst = 0;
      m_ok   = 1;
      pipe_q.delete();
      return;
    end
    if (!m_ok) return;
    acc   = v_in && (m_phase == PH_IDLE);
    empty = (pipe_q.size() == 0) && !f_vout;
    if (v_in && (m_phase != PH_IDLE)) m_drop = 1;
    if (!m_frst) begin
      pipe_q.delete();
    end else begin
      if (f_vout) void'(pipe_q.pop_front());
      for (int i = 0; i < pipe_q.size(); i++) pipe_q[i]++;
      if (acc) pipe_q.push_back(1);
    end
    old_sh = m_sh;
    if (cfg_we && (cfg_addr < 3'd5)) m_sh[cfg_addr] = cfg_data;
    case (m_phase)
      PH_IDLE: if (cfg_commit) m_phase = PH_WAIT;
      PH_WAIT: if (empty) m_phase = PH_COPY;
      PH_COPY: begin
        m_act = old_sh;
        m_phase = PH_ACK;
        n_swaps++;
      end
      default: m_phase = PH_IDLE;
    endcase
    m_frst = (m_phase != PH_COPY);
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, then present filter output.
  task automatic step();
    bit exp_rdy;
    logic [NB-1:0] exp_rdata;
    @(negedge clk);
    if (m_ok) begin
      exp_rdy   = (m_phase == PH_IDLE);
      exp_rdata = (cfg_addr < 3'd5) ? m_sh[cfg_addr] : '0;
      check("rdy",       64'(rdy),       64'(exp_rdy));
      check("cfg_busy",  64'(cfg_busy),  64'(!exp_rdy));
      check("swap_done", 64'(swap_done), 64'(m_phase == PH_ACK));
      check("drop",      64'(drop),      64'(m_drop));
      check("f_rst_n",   64'(f_rst_n),   64'(m_frst));
      check("b",         64'(b),         64'({m_act[2], m_act[1], m_act[0]}));
      check("a",         64'(a),         64'({m_act[4], m_act[3]}));
      check("f_vIn",     64'(f_vin),     64'(v_in && exp_rdy));
      check("f_dIn",     64'(f_din),     64'(d_in));
      check("cfg_rdata", 64'(cfg_rdata), 64'(exp_rdata));
    end
    @(posedge clk);
    model_edge();
    #1;
    f_vout = (pipe_q.size() > 0) && (pipe_q[0] >= LAT);
  endtask

  task automatic idle(input int n);
    v_in = 0; cfg_we = 0; cfg_commit = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] ad, input logic [NB-1:0] dt);
    cfg_we = 1; cfg_addr = ad; cfg_data = dt;
    step();
    cfg_we = 0;
  endtask

  initial begin
    int swaps_before;
    bit post_rst;
    rst_n = 0; cfg_we = 0; cfg_commit = 0; v_in = 0; f_vout = 0;
    cfg_addr = 0; cfg_data = 0; d_in = 0;
    n_vec = 0; n_err = 0; n_swaps = 0;
    m_ok = 0; m_drop = 0; m_frst = 0;
    #1;
    step(); step();
    rst_n = 1;
    idle(3);

    // Shadow write is visible on readback but not on the active bank.
    wr(3'd0, 12'h400);
    cfg_addr = 3'd0;
    idle(2);

    // Commit with an empty filter.
    wr(3'd3, 12'hC00);
    cfg_commit = 1; step(); cfg_commit = 0;
    idle(5);
    check("swap_count_empty", 64'(n_swaps), 64'(1));
    check("b0_after_swap", 64'(b[11:0]), 64'(12'h400));
    check("a1_after_swap", 64'(a[11:0]), 64'(12'hC00));

    // Commit with three samples in flight; commit held to test it is ignored in DRAIN,
    // writes every cycle so one lands in the SWAP cycle, vIn during DRAIN sets drop.
    swaps_before = n_swaps;
    for (int i = 0; i < 3; i++) begin
      v_in = 1; d_in = NB'($urandom);
      cfg_commit = (i == 2);
      step();
    end
    v_in = 1; cfg_commit = 1; step();
    v_in = 0; step();
    cfg_commit = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1; cfg_addr = 3'd1; cfg_data = NB'($urandom);
      step();
    end
    cfg_we = 0;
    idle(4);
    check("swap_count_stream", 64'(n_swaps - swaps_before), 64'(1));
    check("drop_sticky", 64'(drop), 64'(1));

    // Reset in the middle of a drain.
    v_in = 1; step(); step();
    v_in = 0; cfg_commit = 1; step(); cfg_commit = 0;
    step();
    rst_n = 0; step(); rst_n = 1;
    idle(4);
    check("drop_after_reset", 64'(drop), 64'(0));

    // Randomised traffic, commits, writes and rare resets.
    post_rst = 0;
    for (int i = 0; i < 1500; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      v_in       = rst_n && !post_rst && ($urandom_range(0, 1) == 1);
      d_in       = NB'($urandom);
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 3'($urandom_range(0, 7));
      cfg_data   = NB'($urandom);
      cfg_commit = ($urandom_range(0, 24) == 0);
      post_rst   = !rst_n;
      step();
    end
    rst_n = 1;
    idle(20);
    check("filter_drained", 64'(pipe_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
